// File: rtl/random_range.sv
// -----------------------------------------------------------------------------
// random_range
//   Produces a uniformly distributed number in [0, limit) from a free-running
//   random word using bounded rejection sampling.
//
//   Each candidate is the low W bits of random_val ANDed with the smallest
//   all-ones mask covering limit-1. A candidate below the limit is returned.
//   A candidate at or above the limit is rejected and the next cycle's random
//   word is tried instead. After MAX_TRIES consecutive rejections the last
//   candidate is folded back into range (cand - limit) and flagged as a
//   fallback result. This keeps the worst-case latency bounded.
//
// Parameters
//   W          width of limit and value (2..32)
//   MAX_TRIES  maximum sampling attempts per request (2..255)
//
// Ports
//   clk           system clock, all state on rising edge
//   reset         asynchronous, active-high reset
//   random_val    free-running random word, new value every cycle
//   req_valid     request for a number in [0, limit)
//   req_ready     high when a request can be accepted (IDLE)
//   limit         exclusive upper bound, sampled on accept
//   out_valid     value holds a result (DONE)
//   out_ready     consumer accepts the result
//   value         result, 0 <= value < max(limit,1)
//   fallback      result came from the fallback path (qualified by out_valid)
//   reject_count  saturating count of rejected candidates since reset
// -----------------------------------------------------------------------------
module random_range #(
  parameter int W         = 16,
  parameter int MAX_TRIES = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [31:0]  random_val,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [W-1:0] limit,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] value,
  output logic         fallback,
  output logic [15:0]  reject_count
);

  localparam int LOG_W = $clog2(W);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SAMPLE = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t         state_reg, state_next;

  logic [W-1:0]   lim_reg;
  logic [W-1:0]   mask_reg;
  logic [7:0]     try_reg;
  logic [W-1:0]   value_reg;
  logic           fallback_reg;
  logic [15:0]    reject_reg;

  logic           accept;
  logic           trivial_limit;
  logic [W-1:0]   cand;
  logic           cand_hit;
  logic           last_try;

  // ---------------------------------------------------------------------------
  // Mask generation: smear the highest set bit of (limit-1) into every lower
  // position, giving the smallest (2^k)-1 that is >= limit-1. Done with a
  // logarithmic OR-shift chain so the depth is log2(W) rather than W.
  // ---------------------------------------------------------------------------
  logic [W-1:0] smear [0:LOG_W];

  assign smear[0] = limit - W'(1);

  generate
    for (genvar gi = 0; gi < LOG_W; gi++) begin : g_smear
      assign smear[gi+1] = smear[gi] | (smear[gi] >> (1 << gi));
    end
  endgenerate

  // Upper random bits are not needed when W < 32.
  generate
    if (W < 32) begin : g_unused
      logic unused_random_hi;
      assign unused_random_hi = ^random_val[31:W];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Shared combinational terms
  // ---------------------------------------------------------------------------
  assign accept        = req_valid && (state_reg == IDLE);
  assign trivial_limit = (limit < W'(2));
  assign cand          = random_val[W-1:0] & mask_reg;
  assign cand_hit      = (cand < lim_reg);
  // try_reg counts rejections already taken, so this is the final attempt.
  assign last_try      = (try_reg == 8'(MAX_TRIES - 1));

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (req_valid) begin
          state_next = trivial_limit ? DONE : SAMPLE;
        end
      end
      SAMPLE: begin
        if (cand_hit || last_try) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    req_ready = 1'b0;
    out_valid = 1'b0;
    case (state_reg)
      IDLE:    req_ready = 1'b1;
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: request latch, sampling, result and statistics
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lim_reg      <= '0;
      mask_reg     <= '0;
      try_reg      <= '0;
      value_reg    <= '0;
      fallback_reg <= 1'b0;
      reject_reg   <= '0;
    end else begin
      if (accept) begin
        lim_reg  <= limit;
        mask_reg <= smear[LOG_W];
        try_reg  <= '0;
        // Limits 0 and 1 have only one legal answer, resolved immediately.
        if (trivial_limit) begin
          value_reg    <= '0;
          fallback_reg <= 1'b0;
        end
      end else if (state_reg == SAMPLE) begin
        if (cand_hit) begin
          value_reg    <= cand;
          fallback_reg <= 1'b0;
        end else if (last_try) begin
          // cand <= mask <= 2*(lim-1), so cand - lim is always below lim.
          // This final candidate is resolved, not counted as a rejection.
          value_reg    <= cand - lim_reg;
          fallback_reg <= 1'b1;
        end else begin
          try_reg <= try_reg + 8'd1;
          if (reject_reg != 16'hFFFF) begin
            reject_reg <= reject_reg + 16'd1;
          end
        end
      end
    end
  end

  assign value        = value_reg;
  assign fallback     = fallback_reg;
  assign reject_count = reject_reg;

endmodule

// File: doc/random_range.md
RANDOM_RANGE -- requirements
Module: random_range

Interface
REQ-001 SHALL have parameter W, default 16, meaning the width of limit and value.
REQ-002 SHALL have parameter MAX_TRIES, default 16, meaning the maximum number of rejection-sampling attempts per request (range 2..255).
REQ-003 SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port random_val  input  32  free-running random word, new value every cycle.
REQ-006 SHALL have port req_valid  input  1  request for a number in [0, limit).
REQ-007 SHALL have port req_ready  output  1  high when a request can be accepted.
REQ-008 SHALL have port limit  input  W  exclusive upper bound, sampled on accept.
REQ-009 SHALL have port out_valid  output  1  value holds a result.
REQ-010 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-011 SHALL have port value  output  W  result, 0 <= value < max(limit,1).
REQ-012 SHALL have port fallback  output  1  result came from the fallback path, qualified by out_valid.
REQ-013 SHALL have port reject_count  output  16  saturating count of rejected candidates since reset.

Function
REQ-014 SHALL implement states IDLE, SAMPLE, DONE; req_ready = (state==IDLE); out_valid = (state==DONE).
REQ-015 SHALL accept a request on a clock edge with req_valid && req_ready, latching limit into lim_q and clearing the try counter.
REQ-016 SHALL on accept with limit 0 or 1 go directly to DONE with value=0, fallback=0: latency 1 cycle.
REQ-017 SHALL on accept with limit >= 2 compute mask = smallest (2^k)-1 >= lim_q-1 and go to SAMPLE.
REQ-018 SHALL in SAMPLE each cycle form cand = random_val[W-1:0] & mask, using the random_val present in that cycle.
REQ-019 SHALL if cand < lim_q load value=cand, fallback=0, go to DONE: minimum latency 2 cycles accept-to-out_valid.
REQ-020 SHALL if cand >= lim_q increment the try counter and reject_count (saturating at 16'hFFFF) and stay in SAMPLE.
REQ-021 SHALL on the MAX_TRIES-th consecutive rejection load value=cand-lim_q (always < lim_q), fallback=1, go to DONE.
REQ-022 SHALL NOT count the fallback-resolved candidate in reject_count; the count increments by exactly MAX_TRIES-1 per fallback request.
REQ-023 SHALL bound worst-case latency to MAX_TRIES+1 cycles from accept to out_valid.
REQ-024 SHALL hold value and fallback stable in DONE until out_valid && out_ready, then return to IDLE; req_ready rises the next cycle.
REQ-025 SHALL ignore req_valid and limit changes while not in IDLE; no queuing.
REQ-026 SHALL keep value, fallback unchanged in IDLE after handshake (last result retained).

Reset
REQ-027 SHALL on reset assertion immediately (asynchronously) force state=IDLE, value=0, fallback=0, try counter=0, reset_count=0, out_valid=0, req_ready=1.
REQ-028 SHALL abandon any in-flight request on reset mid-SAMPLE or mid-DONE; no result is produced for it.
REQ-029 SHALL require no valid random_val during reset; the first accept is possible on the first edge after reset deassertion.

Verification
REQ-030 Bench SHALL drive limit=10, random_val[15:0]=16'h0007 -> out_valid 2 cycles after accept, value=7, fallback=0, reject_count=0.
REQ-031 Bench SHALL drive limit=10 (mask 15), random_val low bits 13,12,4 on successive cycles -> value=4, 4 cycles after accept, reject_count=2.
REQ-032 Bench SHALL drive limit=5 (mask 7), random_val low bits fixed 7, MAX_TRIES=16 -> out_valid 17 cycles after accept, value=2, fallback=1, reject_count=15.
REQ-033 Bench SHALL drive limit=0 and then limit=1 -> each completes 1 cycle after accept with value=0, fallback=0.
REQ-034 Bench SHALL hold out_ready=0 for 20 cycles in DONE while toggling req_valid/limit -> value stable, no new accept; out_ready=1 -> IDLE next cycle.
REQ-035 Bench SHALL assert reset mid-SAMPLE -> out_valid=0, req_ready=1, reject_count=0 immediately, without waiting for a clock edge.
